// File: rtl/sub_pipe2.sv
// -----------------------------------------------------------------------------
// sub_pipe2 : two-stage pipelined WIDTH-bit subtractor with borrow-in,
//             borrow-out and signed-overflow flags.
//
// result = A - B - bin (mod 2^WIDTH)
//   Stage 1 : subtracts the low halves (with bin) and stores the low-half
//             borrow plus the untouched high halves of A and B.
//   Stage 2 : output register; subtracts the high halves using the stored
//             low-half borrow and produces diff / bout / ovf.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      A, B and bin are valid this cycle
//   in_ready   out  1      block accepts an operand set this cycle (combinational)
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      diff, bout and ovf are valid
//   out_ready  in   1      consumer accepts the result this cycle
//   diff       out  WIDTH  (A - B - bin) mod 2^WIDTH
//   bout       out  1      1 iff unsigned A < B + bin
//   ovf        out  1      1 iff the signed result does not fit in WIDTH bits
//
// WIDTH must be even and at least 2.
// -----------------------------------------------------------------------------
module sub_pipe2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int H  = WIDTH / 2;     // low-half width
    localparam int HW = WIDTH - H;     // high-half width

    // Stage 1 registers
    logic          r_s1_valid;
    logic [H-1:0]  r_s1_dlo;
    logic          r_s1_b1;
    logic [HW-1:0] r_s1_ahi;
    logic [HW-1:0] r_s1_bhi;

    // Stage 2 (output) registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    // Combinational control and datapath
    logic          w_s2_load;
    logic          w_s1_adv;
    logic          w_in_xfer;
    logic [H:0]    w_lo_full;
    logic [HW:0]   w_hi_full;
    logic          w_ovf;

    // Handshake control: stage 1 may take new data when it is empty or when
    // its contents move into the output register in the same cycle.
    always_comb begin
        w_s2_load = r_s1_valid & (~r_out_valid | out_ready);
        w_s1_adv  = ~r_s1_valid | w_s2_load;
        w_in_xfer = in_valid & w_s1_adv;
    end

    // Half-width subtractions; one extra MSB catches the borrow, which is set
    // exactly when the extended difference goes negative.
    always_comb begin
        w_lo_full = {1'b0, A[H-1:0]} - {1'b0, B[H-1:0]} - {{H{1'b0}}, bin};
        w_hi_full = {1'b0, r_s1_ahi} - {1'b0, r_s1_bhi} - {{HW{1'b0}}, r_s1_b1};
        // Overflow only possible when operand signs differ; it happened if the
        // result sign does not match the minuend sign.
        w_ovf     = (r_s1_ahi[HW-1] != r_s1_bhi[HW-1]) &
                    (w_hi_full[HW-1] != r_s1_ahi[HW-1]);
    end

    // Stage 1 register: capture the low-half difference on an input transfer,
    // hold when full and blocked, empty when drained into stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_dlo   <= {H{1'b0}};
            r_s1_b1    <= 1'b0;
            r_s1_ahi   <= {HW{1'b0}};
            r_s1_bhi   <= {HW{1'b0}};
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_dlo   <= w_lo_full[H-1:0];
            r_s1_b1    <= w_lo_full[H];
            r_s1_ahi   <= A[WIDTH-1:H];
            r_s1_bhi   <= B[WIDTH-1:H];
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Output register: load the finished result, drop valid once consumed,
    // otherwise hold everything stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_diff      <= {WIDTH{1'b0}};
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_diff      <= {w_hi_full[HW-1:0], r_s1_dlo};
            r_bout      <= w_hi_full[HW];
            r_ovf       <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: doc/sub_pipe2.md
Name: sub_pipe2

Overview:
- Two-stage pipelined WIDTH-bit subtractor with borrow-in, borrow-out and signed-overflow flags. It is the inverse-direction companion to the team's pipelined adder.
- Stage 1 computes the low half of the difference; stage 2 computes the high half using the registered low-half borrow.
- Valid/ready handshakes on both input and output allow the block to sit in a backpressured datapath, for example the ALU return path.

Parameters:
WIDTH  8  operand width; must be even, minimum 2; split point H = WIDTH/2

Ports:
clk        in   1      rising-edge clock
rst        in   1      synchronous, active-high reset
in_valid   in   1      A, B and bin are valid this cycle
in_ready   out  1      block accepts an operand set this cycle
A          in   WIDTH  minuend (unsigned, or two's complement for ovf)
B          in   WIDTH  subtrahend
bin        in   1      borrow-in; result = A - B - bin
out_valid  out  1      diff, bout and ovf are valid
out_ready  in   1      consumer accepts the result this cycle
diff       out  WIDTH  (A - B - bin) mod 2^WIDTH
bout       out  1      1 iff unsigned A < B + bin
ovf        out  1      1 iff the signed result of A - B - bin is outside the WIDTH-bit two's-complement range

Behaviour:
- Clock and reset: single clock domain clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, diff=0, bout=0, ovf=0. All internal stage valid bits are cleared; internal data registers are cleared to 0.
- in_ready is combinational and equals 1 in the first cycle after reset.
- Transfers: an input transfer occurs on a cycle with in_valid & in_ready; an output transfer occurs on a cycle with out_valid & out_ready.
- Stage 1 register, loaded on an input transfer:
  - {b1, d_lo} = A[H-1:0] - B[H-1:0] - bin; b1 is the low-half borrow.
  - Registers A[WIDTH-1:H] and B[WIDTH-1:H].
  - Sets s1_valid.
- Stage 2 (the output register) loads when s1_valid and (!out_valid | out_ready):
  - {bout, d_hi} = A_hi - B_hi - b1.
  - diff = {d_hi, d_lo}.
  - ovf = (A_hi[msb] != B_hi[msb]) & (diff[msb] != A_hi[msb]).
  - Sets out_valid.
- Handshake and advance rules:
  - Stage 1 advance condition: s1_adv = !s1_valid | stage-2 load.
  - in_ready = s1_adv.
  - s1_valid next = input transfer ? 1 : (stage-2 load ? 0 : s1_valid).
  - out_valid next = stage-2 load ? 1 : (out_ready ? 0 : out_valid).
- Latency: 2 cycles from the input transfer edge to out_valid high. Throughput is 1 result/cycle while out_ready=1.
- Stall:
  - While out_valid & !out_ready, diff, bout and ovf hold stable.
  - Stage 1 holds its contents when full.
  - in_ready falls only when both stages are full.
  - No result is dropped or duplicated; order is FIFO.
- Simultaneous events: a full pipe with out_ready=1 accepts a new input in the same cycle as both stages advance; there is no bubble.
- in_valid=0 with a full pipe: the pipe drains in two cycles (given out_ready=1).
- Reset mid-operation flushes both stages. Results in flight are discarded; out_valid=0 on the cycle after rst is sampled high.
- Wrap-around:
  - diff is modulo 2^WIDTH.
  - bout=1 on unsigned underflow, e.g. 0 - 0 - 1 gives diff all-ones, bout=1.
- A, B and bin are sampled only on an input transfer; values while in_ready=0 are ignored.

Test Plan:
1. Basic: A=8'h50, B=8'h30, bin=0, out_ready=1 -> two cycles later diff=8'h20, bout=0, ovf=0, out_valid high for 1 cycle.
2. Borrow chain: A=8'h10, B=8'h01, bin=0 -> diff=8'h0F, bout=0. A=8'h10, B=8'h0F, bin=1 -> diff=8'h00, bout=0. A=8'h00, B=8'h00, bin=1 -> diff=8'hFF, bout=1, ovf=0.
3. Signed overflow: A=8'h80, B=8'h01 -> diff=8'h7F, bout=0, ovf=1. A=8'h7F, B=8'hFF -> diff=8'h80, bout=1, ovf=1.
4. Back-to-back stream with backpressure:
   - Stimulus: 4 consecutive inputs (8'h05-8'h01, 8'h06-8'h01, 8'h07-8'h01, 8'h08-8'h01); out_ready=0 for cycles 2-5, then 1.
   - Required: in_ready goes low once 2 results are held; outputs 04, 05, 06, 07 in order, none lost; diff is stable during the stall.
5. Full-pipe simultaneous accept: both stages full, out_ready=1, in_valid=1 each cycle -> one result per cycle and in_ready stays 1.
6. Reset mid-flight: issue 2 inputs, assert rst for 1 cycle while both stages are full -> out_valid=0, diff=0 after reset, no stale result ever appears, in_ready=1 the next cycle.
